data_mem_responder: RTL

Responder side of the CPU data-memory port. It accepts one read or write request at a time from the multicycle CPU on the same memRead/memWrite/address/dataIn/dataOut wires the CPU drives. It inserts a programmable number of wait states, then completes the access with a one-cycle memReady pulse. Misaligned, out-of-range and conflicting requests are rejected with memError, and storage is left untouched.

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_ram.sv | 26 ++
 rtl/data_mem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared FSM encoding and address constants for the data-memory responder
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Byte address bits below the 32-bit word index
    localparam int WORD_OFFSET = 2;

    // Wide enough for the largest legal wait-state count (15)
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port word storage with synchronous read and write, no reset
module data_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // rdata only moves on an enabled read so it holds between read responses
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder with programmable wait states and request checking
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] dataOut,
    output logic        memReady,
    output logic        memError,
    output logic        busy
);

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  op_write;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  have_data;
    logic [31:0]           ram_rdata;

    logic accept;
    logic commit;
    logic req_err;

    assign accept = (state == IDLE) && (memRead || memWrite);
    assign commit = (state == WAIT) && (cnt == '0);

    assign req_err = (address[WORD_OFFSET-1:0] != '0)
                  || ((address >> (ADDR_WIDTH + WORD_OFFSET)) != 32'd0)
                  || (memRead && memWrite);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (memRead || memWrite) next_state = WAIT;
            WAIT:    if (cnt == '0) next_state = RESPOND;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            have_data <= 1'b0;
            memReady  <= 1'b0;
            memError  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != IDLE);
            memReady <= (next_state == RESPOND);
            memError <= (next_state == RESPOND) && err_q;

            if (accept) begin
                op_write <= memWrite;
                err_q    <= req_err;
                idx_q    <= address[ADDR_WIDTH+WORD_OFFSET-1:WORD_OFFSET];
                wdata_q  <= dataIn;
                cnt      <= CNT_WIDTH'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (commit && !err_q && !op_write) begin
                have_data <= 1'b1;
            end
        end
    end

    // Storage is not reset, so dataOut reads as zero until the first good read after reset
    assign dataOut = have_data ? ram_rdata : 32'd0;

    data_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (commit && !err_q),
        .we   (op_write),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule
